// File: rtl/pythag_sqrt_seq.sv
// Multi-cycle integer hypotenuse engine: floor(sqrt(x^2 +/- y^2)) via shift-add squaring
// followed by a restoring one-bit-per-cycle square root, with valid/ready on both sides.
module pythag_sqrt_seq #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   root,
  output logic         exact,
  output logic         busy
);

  localparam int unsigned CntW = $clog2(W + 2);
  localparam int unsigned RemW = W + 2;

  typedef enum logic [1:0] {StIdle, StSquare, StSqrt, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [2*W-1:0]      mcand_x_q, mcand_x_d, mcand_y_q, mcand_y_d;
  logic [W-1:0]        mplier_x_q, mplier_x_d, mplier_y_q, mplier_y_d;
  logic [2*W-1:0]      acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [2*W+1:0]      rad_q, rad_d;
  logic [RemW-1:0]     rem_q, rem_d;
  logic [W:0]          racc_q, racc_d;
  logic [W:0]          root_q, root_d;
  logic                exact_q, exact_d;

  logic [2*W-1:0]      acc_x_nxt, acc_y_nxt;
  logic [2*W:0]        rad_sum, rad_diff;
  logic [RemW+1:0]     rem_shift, trial, rem_nxt;
  logic                rem_ge;
  logic [W:0]          racc_nxt;

  always_comb begin
    acc_x_nxt = acc_x_q + (mplier_x_q[0] ? mcand_x_q : '0);
    acc_y_nxt = acc_y_q + (mplier_y_q[0] ? mcand_y_q : '0);
    rad_sum   = {1'b0, acc_x_nxt} + {1'b0, acc_y_nxt};
    rad_diff  = (acc_x_nxt >= acc_y_nxt) ? {1'b0, acc_x_nxt - acc_y_nxt}
                                         : {1'b0, acc_y_nxt - acc_x_nxt};
    // Remainder stays below 2^(W+2) because it never exceeds twice the partial root.
    rem_shift = {rem_q, rad_q[2*W+1:2*W]};
    trial     = {1'b0, racc_q, 2'b01};
    rem_ge    = (rem_shift >= trial);
    rem_nxt   = rem_ge ? (rem_shift - trial) : rem_shift;
    racc_nxt  = {racc_q[W-1:0], rem_ge};

    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    mcand_x_d  = mcand_x_q;
    mcand_y_d  = mcand_y_q;
    mplier_x_d = mplier_x_q;
    mplier_y_d = mplier_y_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    racc_d     = racc_q;
    root_d     = root_q;
    exact_d    = exact_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d    = StSquare;
          cnt_d      = '0;
          mode_d     = mode;
          mcand_x_d  = {{W{1'b0}}, x};
          mcand_y_d  = {{W{1'b0}}, y};
          mplier_x_d = x;
          mplier_y_d = y;
          acc_x_d    = '0;
          acc_y_d    = '0;
          rad_d      = '0;
          rem_d      = '0;
          racc_d     = '0;
        end
      end
      StSquare: begin
        acc_x_d    = acc_x_nxt;
        acc_y_d    = acc_y_nxt;
        mcand_x_d  = mcand_x_q << 1;
        mcand_y_d  = mcand_y_q << 1;
        mplier_x_d = mplier_x_q >> 1;
        mplier_y_d = mplier_y_q >> 1;
        cnt_d      = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StSqrt;
          cnt_d   = '0;
          rad_d   = {1'b0, (mode_q ? rad_diff : rad_sum)};
          rem_d   = '0;
          racc_d  = '0;
        end
      end
      StSqrt: begin
        rem_d  = RemW'(rem_nxt);
        racc_d = racc_nxt;
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W)) begin
          state_d = StDone;
          root_d  = racc_nxt;
          exact_d = (rem_nxt == '0);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      mcand_x_q  <= '0;
      mcand_y_q  <= '0;
      mplier_x_q <= '0;
      mplier_y_q <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      rad_q      <= '0;
      rem_q      <= '0;
      racc_q     <= '0;
      root_q     <= '0;
      exact_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      mcand_x_q  <= mcand_x_d;
      mcand_y_q  <= mcand_y_d;
      mplier_x_q <= mplier_x_d;
      mplier_y_q <= mplier_y_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      racc_q     <= racc_d;
      root_q     <= root_d;
      exact_q    <= exact_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StSquare) || (state_q == StSqrt);
  assign root      = root_q;
  assign exact     = exact_q;

endmodule

// File: tb/tb_pythag_sqrt_seq.sv
// Self-checking bench for pythag_sqrt_seq: directed cases plus random operands at W=8, 4 and 12,
// checked against a plain-arithmetic floor-sqrt model.
module tb_pythag_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  in_valid_s = '0;
  logic [15:0] x_s = '0;
  logic [15:0] y_s = '0;
  logic        mode_s = 1'b0;
  logic        out_ready_s = 1'b1;

  logic [2:0]  in_ready_v, out_valid_v, exact_v, busy_v;
  logic [16:0] root_v [3];
  logic [8:0]  root8;
  logic [4:0]  root4;
  logic [12:0] root12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pythag_sqrt_seq #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_v[0]),
    .x(x_s[7:0]), .y(y_s[7:0]), .mode(mode_s), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_s), .root(root8), .exact(exact_v[0]), .busy(busy_v[0])
  );

  pythag_sqrt_seq #(.W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_v[1]),
    .x(x_s[3:0]), .y(y_s[3:0]), .mode(mode_s), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_s), .root(root4), .exact(exact_v[1]), .busy(busy_v[1])
  );

  pythag_sqrt_seq #(.W(12)) dut_w12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_v[2]),
    .x(x_s[11:0]), .y(y_s[11:0]), .mode(mode_s), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_s), .root(root12), .exact(exact_v[2]), .busy(busy_v[2])
  );

  assign root_v[0] = {8'b0, root8};
  assign root_v[1] = {12'b0, root4};
  assign root_v[2] = {4'b0, root12};

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 4 : 12;
  endfunction

  function automatic void ref_model(input longint xa, input longint ya, input bit md,
                                    output longint r, output bit ex);
    longint rad, lo, hi, mid;
    if (md) rad = (xa * xa > ya * ya) ? xa * xa - ya * ya : ya * ya - xa * xa;
    else    rad = xa * xa + ya * ya;
    lo = 0;
    hi = 64'd1 << 18;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= rad) lo = mid;
      else hi = mid - 1;
    end
    r  = lo;
    ex = (lo * lo == rad);
  endfunction

  // Accepts one operand set on DUT 'sel', waits for out_valid, and completes the handshake
  // when out_ready_s is high.
  task automatic run_op(input int sel, input logic [15:0] xa, input logic [15:0] ya,
                        input bit md, output logic [16:0] r, output bit ex, output int lat,
                        output bit ir_after_accept);
    int n = 0;
    while (!in_ready_v[sel] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (in_ready_v[sel] !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_wait sel=%0d: in_ready=%b required 1", sel, in_ready_v[sel]);
    end
    x_s = xa;
    y_s = ya;
    mode_s = md;
    in_valid_s[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[sel] = 1'b0;
    ir_after_accept = in_ready_v[sel];
    lat = 0;
    while (!out_valid_v[sel] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = root_v[sel];
    ex = exact_v[sel];
    if (out_ready_s) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string name, input int sel, input logic [15:0] xa,
                          input logic [15:0] ya, input bit md);
    logic [16:0] r;
    bit ex, ir;
    int lat;
    longint er;
    bit eex;
    ref_model(longint'(xa), longint'(ya), md, er, eex);
    run_op(sel, xa, ya, md, r, ex, lat, ir);
    n_checks++;
    if (r !== 17'(er) || ex !== eex || lat != 2 * width_of(sel) + 1) begin
      n_fail++;
      $display("FAIL %s W=%0d x=%0d y=%0d mode=%0d: root=%0d exact=%0d lat=%0d required root=%0d exact=%0d lat=%0d",
               name, width_of(sel), xa, ya, md, r, ex, lat, er, eex, 2 * width_of(sel) + 1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid_s = '0;
    out_ready_s = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (in_ready_v[s] !== 1'b1 || out_valid_v[s] !== 1'b0 || root_v[s] !== 17'd0 ||
          exact_v[s] !== 1'b0 || busy_v[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state sel=%0d: ir=%b ov=%b root=%0d ex=%b busy=%b required 1 0 0 0 0",
                 s, in_ready_v[s], out_valid_v[s], root_v[s], exact_v[s], busy_v[s]);
      end
    end
  endtask

  task automatic test_basic();
    logic [16:0] r;
    bit ex, ir;
    int lat;
    run_op(0, 16'd3, 16'd4, 1'b0, r, ex, lat, ir);
    n_checks++;
    if (ir !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_in_ready_drop: in_ready=%b required 0", ir);
    end
    n_checks++;
    if (lat != 17 || r !== 17'd5 || ex !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_3_4: lat=%0d root=%0d exact=%b required 17 5 1", lat, r, ex);
    end
    n_checks++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_handshake: ir=%b ov=%b busy=%b required 1 0 0",
               in_ready_v[0], out_valid_v[0], busy_v[0]);
    end
    n_checks++;
    if (root_v[0] !== 17'd5) begin
      n_fail++;
      $display("FAIL basic_root_held_idle: root=%0d required 5", root_v[0]);
    end
  endtask

  task automatic test_corners();
    check_op("max_sum", 0, 16'd255, 16'd255, 1'b0);
    check_op("zero", 0, 16'd0, 16'd0, 1'b0);
    check_op("diff_5_3", 0, 16'd5, 16'd3, 1'b1);
    check_op("diff_3_5", 0, 16'd3, 16'd5, 1'b1);
    check_op("diff_7_7", 0, 16'd7, 16'd7, 1'b1);
    check_op("diff_max_0", 0, 16'd255, 16'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [16:0] r;
    bit ex, ir;
    int lat;
    out_ready_s = 1'b0;
    run_op(0, 16'd6, 16'd8, 1'b0, r, ex, lat, ir);
    n_checks++;
    if (lat != 17 || r !== 17'd10 || ex !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_result: lat=%0d root=%0d exact=%b required 17 10 1", lat, r, ex);
    end
    x_s = 16'd1;
    y_s = 16'd1;
    mode_s = 1'b0;
    in_valid_s[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid_v[0] !== 1'b1 || root_v[0] !== 17'd10 || exact_v[0] !== 1'b1 ||
          in_ready_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: ov=%b root=%0d ex=%b ir=%b required 1 10 1 0",
                 i, out_valid_v[0], root_v[0], exact_v[0], in_ready_v[0]);
      end
    end
    in_valid_s[0] = 1'b0;
    out_ready_s = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || root_v[0] !== 17'd10) begin
      n_fail++;
      $display("FAIL bp_release: ov=%b ir=%b root=%0d required 0 1 10",
               out_valid_v[0], in_ready_v[0], root_v[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stays_idle: busy=%b ir=%b required 0 1", busy_v[0], in_ready_v[0]);
    end
  endtask

  task automatic test_reset_mid();
    x_s = 16'd12;
    y_s = 16'd5;
    mode_s = 1'b0;
    in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid_v[0] !== 1'b0 || root_v[0] !== 17'd0 || busy_v[0] !== 1'b0 ||
        exact_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: ov=%b root=%0d busy=%b ex=%b required 0 0 0 0",
               out_valid_v[0], root_v[0], busy_v[0], exact_v[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_op("after_reset_1_1", 0, 16'd1, 16'd1, 1'b0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 25; i++) begin
        logic [15:0] mask, xa, ya;
        bit md;
        mask = 16'((32'd1 << width_of(s)) - 1);
        xa = 16'($urandom) & mask;
        ya = 16'($urandom) & mask;
        md = 1'($urandom_range(0, 1));
        check_op("random", s, xa, ya, md);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
